trivium_ctrl: RTL and testbench
===============================

Name: trivium_ctrl

Overview:
- Initiator/driver side of the bit-serial Trivium cipher engine's load and data interface.
- Accepts key and IV as 32-bit words over a valid/ready handshake and issues the one-hot load pulses for engine registers A and B.
- Runs the warm-up rounds with output discarded.
- Then serialises 32-bit plaintext words into the engine LSB-first and reassembles the returned ciphertext bits into 32-bit output words.
- Sits between the bus-facing wrapper and the cipher engine instance.

Parameters:
INIT_CYCLES, 1152, number of engine clock-enable cycles in warm-up (4 x 288)
CNT_W, 11, width of warm-up counter; must hold INIT_CYCLES-1

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
rekey_i  in  1  synchronous restart: abandon current session, return to key load
cfg_dat_i  in  32  key/IV word: key w0,w1,w2 then IV w0,w1,w2
cfg_vld_i  in  1  cfg word valid
cfg_rdy_o  out  1  cfg word accepted when vld&rdy
din_i  in  32  plaintext word
din_vld_i  in  1  plaintext valid
din_rdy_o  out  1  plaintext accepted when vld&rdy
dout_o  out  32  ciphertext word
dout_vld_o  out  1  ciphertext valid
dout_rdy_i  in  1  downstream ready
init_done_o  out  1  high in STREAM state
eng_ce_o  out  1  engine chip enable
eng_ld_dat_o  out  32  engine load data
eng_ld_reg_a_o  out  3  one-hot word select for register A (key)
eng_ld_reg_b_o  out  3  one-hot word select for register B (IV)
eng_dat_o  out  1  bit to engine dat_i
eng_dat_i  in  1  bit from engine dat_o (combinational XOR of eng_dat_o with keystream)

Behaviour:
- Interface: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset values:
  - All registered outputs are 0; dout_o is 0.
  - State is IDLE; cfg_rdy_o, din_rdy_o and init_done_o are 0.
- States: IDLE -> LOAD_KEY -> LOAD_IV -> WARMUP -> STREAM.
- IDLE:
  - Unconditional move to LOAD_KEY next cycle.
  - Word index k and all counters are cleared.
- LOAD_KEY / LOAD_IV:
  - cfg_rdy_o = 1 (combinational on state, gated by !rekey_i). One word may be accepted per cycle.
  - Word k accepted in cycle t: in cycle t+1, eng_ld_reg_a_o (KEY) or eng_ld_reg_b_o (IV) = 1<<k, eng_ld_dat_o = word, eng_ce_o = 1.
  - Otherwise the load selects are 000 and eng_ce_o = 0.
  - Word index k runs 0..2. After key w2 the state moves to LOAD_IV with k=0. After IV w2 the state moves to WARMUP.
  - The IV w2 load pulse is the first cycle of WARMUP state output.
- WARMUP:
  - Starts the cycle after the IV w2 pulse.
  - eng_ce_o = 1 and eng_dat_o = 0 for exactly INIT_CYCLES consecutive cycles. eng_dat_i is ignored.
  - The counter counts 0..INIT_CYCLES-1, then the state moves to STREAM.
  - cfg_rdy_o = din_rdy_o = 0.
- STREAM:
  - init_done_o = 1.
  - din_rdy_o = 1 when the serialiser is idle.
  - An accepted word is loaded into the serialiser with bit index n = 0.
  - For each bit n, one cycle with eng_ce_o = 1 and eng_dat_o = word[n]. eng_dat_i is captured into result[n] in that same cycle.
- Output completion:
  - Bit 31 completes only if the output register is free, i.e. !dout_vld_o, or dout_rdy_i in that cycle.
  - Otherwise the serialiser holds at n = 31 with eng_ce_o = 0 and the engine state is frozen.
  - dout_vld_o rises the cycle after bit 31 completes and holds, with dout_o stable, until dout_rdy_i.
- Latency: din accept at t gives bits in t+1..t+32 and dout_vld_o at t+33 when there is no stall.
- Back-to-back: din_rdy_o is high again in the cycle after bit 31. Throughput is 1 word per 33 cycles.
- eng_ce_o = 0 whenever no load, warm-up or data bit is active.
- rekey_i:
  - Takes priority over any handshake in the same cycle.
  - Next state is LOAD_KEY with k = 0.
  - Serialiser and counter are cleared; dout_vld_o is cleared and any pending word is discarded.
  - eng_ce_o = 0 that cycle.
- Reset mid-operation: async return to IDLE and reset values. A partially loaded key requires a full reload.
- Extra cfg_vld_i outside the load states is ignored (cfg_rdy_o = 0). din_vld_i before STREAM is ignored.

Test Plan:
- Load: 6 words 0x11111111..0x66666666, one per cycle, vld held -> eng_ld_reg_a_o = 001,010,100 then eng_ld_reg_b_o = 001,010,100 on consecutive cycles with matching eng_ld_dat_o, eng_ce_o = 1 on each.
- Warm-up: after load -> exactly 1152 cycles of eng_ce_o = 1, eng_dat_o = 0, then init_done_o = 1. Repeat with INIT_CYCLES = 8 -> 8 cycles.
- Stream with stub engine eng_dat_i = ~eng_dat_o: din 0xA5A5A5A5 -> dout_o = 0x5A5A5A5A, dout_vld_o 33 cycles after accept. eng_dat_o sequence is LSB-first 1,0,1,0,0,1,0,1,...
- Backpressure: dout_rdy_i = 0 with one word pending and a second word sent -> second word stalls at bit 31 with eng_ce_o = 0 until dout_rdy_i; both outputs correct, no extra ce cycles. Total ce count 64.
- rekey_i asserted mid-stream at bit 10 -> next cycle LOAD_KEY, cfg_rdy_o = 1, dout_vld_o = 0, init_done_o = 0, eng_ce_o = 0.
- rst_i pulse during WARMUP cycle 500 -> outputs 0 immediately. After release: IDLE, then LOAD_KEY, and a full reload runs a full 1152-cycle warm-up.

Source files
------------

// File: rtl/trivium_ctrl.sv
// Load/stream controller for a bit-serial Trivium engine: key/IV word loading,
// warm-up rounds, then LSB-first serialisation of plaintext and reassembly of ciphertext.
module trivium_ctrl #(
  parameter int INIT_CYCLES = 1152,
  parameter int CNT_W       = 11
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rekey_i,
  input  logic [31:0] cfg_dat_i,
  input  logic        cfg_vld_i,
  output logic        cfg_rdy_o,
  input  logic [31:0] din_i,
  input  logic        din_vld_i,
  output logic        din_rdy_o,
  output logic [31:0] dout_o,
  output logic        dout_vld_o,
  input  logic        dout_rdy_i,
  output logic        init_done_o,
  output logic        eng_ce_o,
  output logic [31:0] eng_ld_dat_o,
  output logic [2:0]  eng_ld_reg_a_o,
  output logic [2:0]  eng_ld_reg_b_o,
  output logic        eng_dat_o,
  input  logic        eng_dat_i
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_KEY = 3'd1;
  localparam logic [2:0] S_LOAD_IV  = 3'd2;
  localparam logic [2:0] S_WARMUP   = 3'd3;
  localparam logic [2:0] S_STREAM   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

  logic [2:0]       state;
  logic [1:0]       k;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic [31:0]      sh;
  logic [30:0]      res;
  logic [4:0]       n;

  logic in_load, cfg_acc, din_acc, out_free, bit_act, ld_act;

  assign in_load     = (state == S_LOAD_KEY) || (state == S_LOAD_IV);
  assign cfg_rdy_o   = in_load && !rekey_i;
  assign cfg_acc     = cfg_vld_i && cfg_rdy_o;
  assign din_rdy_o   = (state == S_STREAM) && !busy && !rekey_i;
  assign din_acc     = din_vld_i && din_rdy_o;
  assign init_done_o = (state == S_STREAM);

  // The final bit may only complete when the output register can take the word.
  assign out_free = !dout_vld_o || dout_rdy_i;
  assign bit_act  = (state == S_STREAM) && busy && ((n != 5'd31) || out_free) && !rekey_i;
  assign ld_act   = (eng_ld_reg_a_o != 3'b000) || (eng_ld_reg_b_o != 3'b000);

  assign eng_ce_o  = !rekey_i && (ld_act || (state == S_WARMUP) || bit_act);
  assign eng_dat_o = (state == S_STREAM) && busy && sh[0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      k              <= '0;
      cnt            <= '0;
      busy           <= 1'b0;
      sh             <= '0;
      res            <= '0;
      n              <= '0;
      dout_o         <= '0;
      dout_vld_o     <= 1'b0;
      eng_ld_dat_o   <= '0;
      eng_ld_reg_a_o <= '0;
      eng_ld_reg_b_o <= '0;
    end else if (rekey_i) begin
      state          <= S_LOAD_KEY;
      k              <= '0;
      cnt            <= '0;
      busy           <= 1'b0;
      n              <= '0;
      dout_vld_o     <= 1'b0;
      eng_ld_reg_a_o <= '0;
      eng_ld_reg_b_o <= '0;
    end else begin
      eng_ld_reg_a_o <= '0;
      eng_ld_reg_b_o <= '0;
      // NOTE: later non-blocking assignments win, so a completing word below overrides this clear.
      if (dout_vld_o && dout_rdy_i) dout_vld_o <= 1'b0;

      case (state)
        S_IDLE: begin
          state <= S_LOAD_KEY;
          k     <= '0;
          cnt   <= '0;
          busy  <= 1'b0;
          n     <= '0;
        end
        S_LOAD_KEY: if (cfg_acc) begin
          eng_ld_reg_a_o <= 3'b001 << k;
          eng_ld_dat_o   <= cfg_dat_i;
          if (k == 2'd2) begin
            k     <= '0;
            state <= S_LOAD_IV;
          end else begin
            k <= k + 2'd1;
          end
        end
        S_LOAD_IV: if (cfg_acc) begin
          eng_ld_reg_b_o <= 3'b001 << k;
          eng_ld_dat_o   <= cfg_dat_i;
          if (k == 2'd2) begin
            k     <= '0;
            cnt   <= '0;
            state <= S_WARMUP;
          end else begin
            k <= k + 2'd1;
          end
        end
        S_WARMUP: begin
          // First WARMUP cycle carries the IV w2 pulse and is not a warm-up round.
          if (eng_ld_reg_b_o == 3'b000) begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= S_STREAM;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (din_acc) begin
            busy <= 1'b1;
            sh   <= din_i;
            n    <= '0;
          end else if (bit_act) begin
            res <= {eng_dat_i, res[30:1]};
            sh  <= sh >> 1;
            n   <= n + 5'd1;
            if (n == 5'd31) begin
              busy       <= 1'b0;
              dout_o     <= {eng_dat_i, res};
              dout_vld_o <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trivium_ctrl.sv
// Directed bench for trivium_ctrl with an inverting stub engine; a second
// instance with a short warm-up shares the stimulus.
module tb_trivium_ctrl;

  logic        clk = 1'b0;
  logic        rst, rekey;
  logic [31:0] cfg_dat, din_dat;
  logic        cfg_vld, din_vld, dout_rdy;

  logic        cfg_rdy, din_rdy, dout_vld, init_done, ce, eng_dat_o, eng_dat_i;
  logic [31:0] dout, ld_dat;
  logic [2:0]  ld_a, ld_b;

  logic        cfg_rdy8, din_rdy8, dout_vld8, init_done8, ce8, eng_dat_o8, eng_dat_i8;
  logic [31:0] dout8, ld_dat8;
  logic [2:0]  ld_a8, ld_b8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign eng_dat_i  = ~eng_dat_o;
  assign eng_dat_i8 = ~eng_dat_o8;

  trivium_ctrl u_dut (
    .clk_i(clk), .rst_i(rst), .rekey_i(rekey),
    .cfg_dat_i(cfg_dat), .cfg_vld_i(cfg_vld), .cfg_rdy_o(cfg_rdy),
    .din_i(din_dat), .din_vld_i(din_vld), .din_rdy_o(din_rdy),
    .dout_o(dout), .dout_vld_o(dout_vld), .dout_rdy_i(dout_rdy),
    .init_done_o(init_done), .eng_ce_o(ce), .eng_ld_dat_o(ld_dat),
    .eng_ld_reg_a_o(ld_a), .eng_ld_reg_b_o(ld_b),
    .eng_dat_o(eng_dat_o), .eng_dat_i(eng_dat_i)
  );

  trivium_ctrl #(.INIT_CYCLES(8), .CNT_W(11)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .rekey_i(rekey),
    .cfg_dat_i(cfg_dat), .cfg_vld_i(cfg_vld), .cfg_rdy_o(cfg_rdy8),
    .din_i(din_dat), .din_vld_i(din_vld), .din_rdy_o(din_rdy8),
    .dout_o(dout8), .dout_vld_o(dout_vld8), .dout_rdy_i(dout_rdy),
    .init_done_o(init_done8), .eng_ce_o(ce8), .eng_ld_dat_o(ld_dat8),
    .eng_ld_reg_a_o(ld_a8), .eng_ld_reg_b_o(ld_b8),
    .eng_dat_o(eng_dat_o8), .eng_dat_i(eng_dat_i8)
  );

  typedef struct {
    logic [31:0] word;
    logic [2:0]  sel_a;
    logic [2:0]  sel_b;
  } ld_vec_t;

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
  } st_vec_t;

  ld_vec_t ld_tbl[6];
  st_vec_t st_tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_cfg_rdy"},   cfg_rdy,   0);
    check({tag, "_din_rdy"},   din_rdy,   0);
    check({tag, "_init_done"}, init_done, 0);
    check({tag, "_ce"},        ce,        0);
    check({tag, "_dout_vld"},  dout_vld,  0);
    check({tag, "_dout"},      dout,      0);
    check({tag, "_ld_a"},      ld_a,      0);
    check({tag, "_ld_b"},      ld_b,      0);
    check({tag, "_ld_dat"},    ld_dat,    0);
    check({tag, "_eng_dat"},   eng_dat_o, 0);
  endtask

  // Starts in a LOAD_KEY cycle; ends in the cycle carrying the IV w2 pulse.
  task automatic load_all();
    for (int i = 0; i <= 6; i++) begin
      start_cyc();
      if (i < 6) begin
        cfg_vld = 1'b1;
        cfg_dat = ld_tbl[i].word;
      end else begin
        cfg_vld = 1'b0;
      end
      #1;
      if (i < 6) check("load_cfg_rdy", cfg_rdy, 1);
      if (i > 0) begin
        check("load_sel_a", ld_a, ld_tbl[i-1].sel_a);
        check("load_sel_b", ld_b, ld_tbl[i-1].sel_b);
        check("load_dat",   ld_dat, ld_tbl[i-1].word);
        check("load_ce",    ce, 1);
      end
    end
  endtask

  task automatic run_warm(input int limit, output int cnt, output int cnt8, output logic done);
    cnt  = 0;
    cnt8 = 0;
    done = 1'b0;
    for (int c = 0; c < limit; c++) begin
      start_cyc();
      #1;
      if (init_done) begin
        done = 1'b1;
        break;
      end
      if (ce && ld_a == 3'b000 && ld_b == 3'b000 && !eng_dat_o) cnt++;
      if (ce8 && ld_a8 == 3'b000 && ld_b8 == 3'b000 && !init_done8 && !eng_dat_o8) cnt8++;
    end
  endtask

  // One word with the output always drained: accept, 32 bit cycles, result on the 33rd.
  task automatic send_word(input logic [31:0] w, input logic [31:0] exp);
    start_cyc();
    din_dat  = w;
    din_vld  = 1'b1;
    dout_rdy = 1'b1;
    #1;
    check("st_din_rdy", din_rdy, 1);
    check("st_idle_ce", ce, 0);
    for (int c = 1; c <= 32; c++) begin
      start_cyc();
      din_vld = 1'b0;
      #1;
      check("st_bit", {ce, eng_dat_o}, {1'b1, w[c-1]});
      if (c == 32) check("st_vld_early", dout_vld, 0);
    end
    start_cyc();
    #1;
    check("st_vld",      dout_vld, 1);
    check("st_dout",     dout, exp);
    check("st_din_rdy2", din_rdy, 1);
  endtask

  int   wcnt, wcnt8, ce_cnt;
  logic wdone;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    ld_tbl[0] = '{32'h11111111, 3'b001, 3'b000};
    ld_tbl[1] = '{32'h22222222, 3'b010, 3'b000};
    ld_tbl[2] = '{32'h33333333, 3'b100, 3'b000};
    ld_tbl[3] = '{32'h44444444, 3'b000, 3'b001};
    ld_tbl[4] = '{32'h55555555, 3'b000, 3'b010};
    ld_tbl[5] = '{32'h66666666, 3'b000, 3'b100};

    st_tbl[0] = '{32'hA5A5A5A5, 32'h5A5A5A5A};
    st_tbl[1] = '{32'h00000000, 32'hFFFFFFFF};
    st_tbl[2] = '{32'hFFFFFFFF, 32'h00000000};
    st_tbl[3] = '{32'h12345678, 32'hEDCBA987};
    st_tbl[4] = '{32'h80000001, 32'h7FFFFFFE};

    rst = 1'b1; rekey = 1'b0;
    cfg_dat = '0; cfg_vld = 1'b0;
    din_dat = '0; din_vld = 1'b0; dout_rdy = 1'b0;

    #12;
    check_zero_outputs("reset");
    // A stray word before STREAM must not be taken.
    din_vld = 1'b1;

    start_cyc();
    rst = 1'b0;
    #1;
    check("idle_cfg_rdy", cfg_rdy, 0);
    check("idle_din_rdy", din_rdy, 0);
    din_vld = 1'b0;

    load_all();
    run_warm(3000, wcnt, wcnt8, wdone);
    check("warm_done",   wdone, 1);
    check("warm_cycles", wcnt, 1152);
    check("warm8_cycles", wcnt8, 8);

    for (int i = 0; i < 5; i++) send_word(st_tbl[i].din, st_tbl[i].dout);

    // Backpressure: first result held, second word must stall at its last bit.
    ce_cnt = 0;
    start_cyc();
    din_dat = 32'h12345678; din_vld = 1'b1; dout_rdy = 1'b0;
    #1;
    check("bp_din_rdy", din_rdy, 1);
    for (int c = 1; c <= 70; c++) begin
      start_cyc();
      din_vld = 1'b0;
      if (c == 33) begin
        din_dat = 32'h0F0F0F0F;
        din_vld = 1'b1;
      end
      if (c == 70) dout_rdy = 1'b1;
      #1;
      if (ce) ce_cnt++;
      if (c == 33) begin
        check("bp_vld1",    dout_vld, 1);
        check("bp_dout1",   dout, 32'hEDCBA987);
        check("bp_din_rdy2", din_rdy, 1);
      end
      if (c >= 65 && c <= 69) begin
        check("bp_stall_ce", ce, 0);
        check("bp_hold",     dout, 32'hEDCBA987);
      end
      if (c == 70) check("bp_release_ce", ce, 1);
    end
    check("bp_ce_total", ce_cnt, 64);

    start_cyc();
    dout_rdy = 1'b0;
    din_dat  = 32'hA5A5A5A5;
    din_vld  = 1'b1;
    #1;
    check("bp_vld2",  dout_vld, 1);
    check("bp_dout2", dout, 32'hF0F0F0F0);

    // Rekey at bit 10 of the next word while a result is still pending.
    for (int c = 72; c <= 82; c++) begin
      start_cyc();
      din_vld = 1'b0;
      if (c == 82) rekey = 1'b1;
      #1;
      if (c == 82) begin
        check("rk_ce",       ce, 0);
        check("rk_vld_held", dout_vld, 1);
      end
    end
    start_cyc();
    rekey = 1'b0;
    #1;
    check("rk_cfg_rdy",   cfg_rdy, 1);
    check("rk_dout_vld",  dout_vld, 0);
    check("rk_init_done", init_done, 0);
    check("rk_ce_after",  ce, 0);

    // Reload, then reset in the middle of warm-up.
    load_all();
    run_warm(500, wcnt, wcnt8, wdone);
    check("warm_partial_done", wdone, 0);
    check("warm_partial_cnt",  wcnt, 500);
    rst = 1'b1;
    #1;
    check_zero_outputs("midrst");

    start_cyc();
    rst = 1'b0;
    #1;
    check("rst_idle_cfg_rdy", cfg_rdy, 0);
    load_all();
    run_warm(3000, wcnt, wcnt8, wdone);
    check("rewarm_done",    wdone, 1);
    check("rewarm_cycles",  wcnt, 1152);
    check("rewarm8_cycles", wcnt8, 8);

    send_word(32'hA5A5A5A5, 32'h5A5A5A5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
